// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS register-file write side.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int AW     = 5;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_if.sv
// Bus between the execute/decode stages and the register-file write front end.
interface reg_writeback_if #(
  parameter int PTR_W = 2
);
  import mips_pkg::*;

  // Handshake: the ALU result has no ready and is taken whenever ALU_VALID is high.
  // A load transfers on any rising CLK where LD_VALID & LD_RDY; while LD_VALID is high
  // and LD_RDY is low the source must hold LD_ADDR/LD_DATA stable.
  logic              ALU_VALID;
  logic [AW-1:0]     ALU_ADDR;
  logic [DATA_W-1:0] ALU_DATA;
  logic              LD_VALID;
  logic              LD_RDY;
  logic [AW-1:0]     LD_ADDR;
  logic [DATA_W-1:0] LD_DATA;
  logic [AW-1:0]     R_Addr_A;
  logic [AW-1:0]     R_Addr_B;
  logic              HAZ_A;
  logic              HAZ_B;
  logic [AW-1:0]     W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              WE;
  logic [PTR_W:0]    COUNT;

  modport master (
    output ALU_VALID, ALU_ADDR, ALU_DATA, LD_VALID, LD_ADDR, LD_DATA, R_Addr_A, R_Addr_B,
    input  LD_RDY, HAZ_A, HAZ_B, W_Addr, W_Data, WE, COUNT
  );

  modport slave (
    input  ALU_VALID, ALU_ADDR, ALU_DATA, LD_VALID, LD_ADDR, LD_DATA, R_Addr_A, R_Addr_B,
    output LD_RDY, HAZ_A, HAZ_B, W_Addr, W_Data, WE, COUNT
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending load results with per-address kill and live-match queries.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic             kill_en,
  input  logic [AW-1:0]    kill_addr,
  input  logic [AW-1:0]    q_addr_a,
  input  logic [AW-1:0]    q_addr_b,
  output wb_entry_t        head,
  output logic [PTR_W:0]   count,
  output logic [DEPTH-1:0] match_a,
  output logic [DEPTH-1:0] match_b
);
  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Popped slots drop their live bit, so live implies occupied and the match
  // vectors need no occupancy mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].addr == kill_addr) mem[i].live <= 1'b0;
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = mem[i].live && (mem[i].addr == q_addr_a);
      match_b[i] = mem[i].live && (mem[i].addr == q_addr_b);
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// Merges ALU and load results onto the single register-file write port and
// reports read-port hazards against writes still in flight.
module reg_writeback
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic           CLK,
  input logic           RST,
  reg_writeback_if.slave bus
);
  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic [PTR_W:0]    count;
  logic [DEPTH-1:0]  match_a;
  logic [DEPTH-1:0]  match_b;
  logic              full;
  logic              empty;
  logic              kill_en;
  logic              ld_accept;
  logic              pop;
  logic [AW-1:0]     w_addr;
  logic [DATA_W-1:0] w_data;
  logic              we;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign kill_en   = bus.ALU_VALID && (bus.ALU_ADDR != REG_ZERO);
  assign ld_accept = bus.LD_VALID && !full;
  assign pop       = !bus.ALU_VALID && !empty;

  // The ALU result is younger than a load arriving in the same cycle, so such a load is born dead.
  assign push_entry = '{addr: bus.LD_ADDR,
                        data: bus.LD_DATA,
                        live: !(kill_en && bus.LD_ADDR == bus.ALU_ADDR)};

  wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (ld_accept),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (kill_en),
    .kill_addr  (bus.ALU_ADDR),
    .q_addr_a   (bus.R_Addr_A),
    .q_addr_b   (bus.R_Addr_B),
    .head       (head),
    .count      (count),
    .match_a    (match_a),
    .match_b    (match_b)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_addr <= '0;
      w_data <= '0;
      we     <= 1'b0;
    end else if (bus.ALU_VALID) begin
      w_addr <= bus.ALU_ADDR;
      w_data <= bus.ALU_DATA;
      we     <= (bus.ALU_ADDR != REG_ZERO);
    end else if (pop) begin
      w_addr <= head.addr;
      w_data <= head.data;
      we     <= head.live && (head.addr != REG_ZERO);
    end else begin
      we     <= 1'b0;
    end
  end

  assign bus.W_Addr = w_addr;
  assign bus.W_Data = w_data;
  assign bus.WE     = we;
  assign bus.LD_RDY = !full;
  assign bus.COUNT  = count;

  assign bus.HAZ_A = (bus.R_Addr_A != REG_ZERO) &&
                     ((|match_a) || (we && w_addr == bus.R_Addr_A));
  assign bus.HAZ_B = (bus.R_Addr_B != REG_ZERO) &&
                     ((|match_b) || (we && w_addr == bus.R_Addr_B));
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenario tasks plus a write-port scoreboard.
module tb_reg_writeback;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [AW+DATA_W-1:0] exp_q[$];

  reg_writeback_if #(.PTR_W(PTR_W)) bus ();

  reg_writeback #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ALU_VALID = 1'b0;
    bus.ALU_ADDR  = '0;
    bus.ALU_DATA  = '0;
    bus.LD_VALID  = 1'b0;
    bus.LD_ADDR   = '0;
    bus.LD_DATA   = '0;
    bus.R_Addr_A  = '0;
    bus.R_Addr_B  = '0;
  endtask

  task automatic drive_alu(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    bus.ALU_VALID = 1'b1;
    bus.ALU_ADDR  = a;
    bus.ALU_DATA  = d;
  endtask

  task automatic drive_ld(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    bus.LD_VALID = 1'b1;
    bus.LD_ADDR  = a;
    bus.LD_DATA  = d;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || bus.COUNT != 0); i++) cycle();
    cycle();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge CLK) begin
    if (!RST && bus.WE === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got write addr=%0d data=%h, required no write",
                 bus.W_Addr, bus.W_Data);
      end else begin
        logic [AW+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.W_Addr, bus.W_Data} !== e) begin
          failures++;
          $display("FAIL wb_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.W_Addr, bus.W_Data, e[AW+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    #1 RST = 1'b1;
    @(negedge CLK);
    checks++; if (bus.COUNT !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d required 0", bus.COUNT); end
    checks++; if (bus.WE !== 1'b0) begin failures++; $display("FAIL rst_we: got %b required 0", bus.WE); end
    checks++; if (bus.W_Addr !== 5'd0) begin failures++; $display("FAIL rst_waddr: got %0d required 0", bus.W_Addr); end
    checks++; if (bus.W_Data !== 32'd0) begin failures++; $display("FAIL rst_wdata: got %h required 0", bus.W_Data); end
    @(negedge CLK) RST = 1'b0;
    cycle();
    checks++; if (bus.LD_RDY !== 1'b1) begin failures++; $display("FAIL rst_ldrdy: got %b required 1", bus.LD_RDY); end
    // queue three loads behind ALU writes to r0, then reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive_alu(5'd0, $urandom);
      drive_ld(5'(10 + i), $urandom);
      cycle();
    end
    bus.LD_VALID = 1'b0;
    checks++; if (bus.COUNT !== 3'd3) begin failures++; $display("FAIL rst_fill: got %0d required 3", bus.COUNT); end
    #2 RST = 1'b1;
    #1;
    idle_inputs();
    checks++; if (bus.COUNT !== 3'd0) begin failures++; $display("FAIL rst_mid_count: got %0d required 0", bus.COUNT); end
    checks++; if (bus.WE !== 1'b0) begin failures++; $display("FAIL rst_mid_we: got %b required 0", bus.WE); end
    @(negedge CLK) RST = 1'b0;
    cycle();
    checks++; if (bus.LD_RDY !== 1'b1) begin failures++; $display("FAIL rst_mid_ldrdy: got %b required 1", bus.LD_RDY); end
    checks++; if (bus.COUNT !== 3'd0) begin failures++; $display("FAIL rst_mid_count2: got %0d required 0", bus.COUNT); end
    repeat (4) cycle();
  endtask

  task automatic test_alu();
    drive_alu(5'd5, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    cycle();
    bus.ALU_VALID = 1'b0;
    checks++; if (bus.WE !== 1'b1) begin failures++; $display("FAIL alu_we: got %b required 1", bus.WE); end
    checks++; if (bus.W_Addr !== 5'd5) begin failures++; $display("FAIL alu_waddr: got %0d required 5", bus.W_Addr); end
    checks++; if (bus.W_Data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wdata: got %h required deadbeef", bus.W_Data); end
    drive_alu(5'd0, 32'h1234);
    cycle();
    bus.ALU_VALID = 1'b0;
    checks++; if (bus.WE !== 1'b0) begin failures++; $display("FAIL alu_r0_we: got %b required 0", bus.WE); end
    cycle();
    checks++; if (bus.WE !== 1'b0) begin failures++; $display("FAIL alu_idle_we: got %b required 0", bus.WE); end
    checks++; if (bus.W_Data !== 32'h1234) begin failures++; $display("FAIL alu_hold_wdata: got %h required 1234", bus.W_Data); end
    wait_drain();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL alu_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_priority();
    logic [AW-1:0]     la [4];
    logic [DATA_W-1:0] ldd[4];
    for (int k = 0; k < 5; k++) begin
      logic [DATA_W-1:0] ad;
      logic [DATA_W-1:0] d;
      checks++; if (bus.COUNT !== 3'(k)) begin failures++; $display("FAIL prio_count%0d: got %0d required %0d", k, bus.COUNT, k); end
      checks++; if (bus.LD_RDY !== (k < 4)) begin failures++; $display("FAIL prio_ldrdy%0d: got %b required %b", k, bus.LD_RDY, k < 4); end
      ad = $urandom;
      d  = $urandom;
      drive_alu(5'(20 + k), ad);
      exp_q.push_back({5'(20 + k), ad});
      drive_ld(5'(1 + k), d);
      if (k < 4) begin
        la[k]  = 5'(1 + k);
        ldd[k] = d;
      end
      cycle();
    end
    idle_inputs();
    for (int j = 0; j < 4; j++) exp_q.push_back({la[j], ldd[j]});
    checks++; if (bus.COUNT !== 3'd4) begin failures++; $display("FAIL prio_full: got %0d required 4", bus.COUNT); end
    for (int j = 0; j < 4; j++) begin
      cycle();
      checks++; if (bus.WE !== 1'b1 || bus.W_Addr !== la[j]) begin
        failures++; $display("FAIL prio_order%0d: got we=%b addr=%0d required we=1 addr=%0d", j, bus.WE, bus.W_Addr, la[j]);
      end
    end
    cycle();
    checks++; if (bus.WE !== 1'b0 || bus.COUNT !== 3'd0) begin
      failures++; $display("FAIL prio_end: got we=%b count=%0d required we=0 count=0", bus.WE, bus.COUNT);
    end
    wait_drain();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL prio_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_kill();
    drive_alu(5'd0, 32'h0);
    drive_ld(5'd7, 32'h11);
    cycle();
    bus.LD_VALID = 1'b0;
    drive_alu(5'd7, 32'h22);
    exp_q.push_back({5'd7, 32'h22});
    bus.R_Addr_A = 5'd7;
    #1;
    checks++; if (bus.HAZ_A !== 1'b1) begin failures++; $display("FAIL kill_haz_before: got %b required 1", bus.HAZ_A); end
    cycle();
    bus.ALU_VALID = 1'b0;
    checks++; if (bus.WE !== 1'b1 || bus.W_Data !== 32'h22) begin
      failures++; $display("FAIL kill_alu: got we=%b data=%h required we=1 data=22", bus.WE, bus.W_Data);
    end
    checks++; if (bus.COUNT !== 3'd1) begin failures++; $display("FAIL kill_count: got %0d required 1", bus.COUNT); end
    cycle();
    checks++; if (bus.WE !== 1'b0 || bus.COUNT !== 3'd0) begin
      failures++; $display("FAIL kill_dead_pop: got we=%b count=%0d required we=0 count=0", bus.WE, bus.COUNT);
    end
    checks++; if (bus.HAZ_A !== 1'b0) begin failures++; $display("FAIL kill_haz_after: got %b required 0", bus.HAZ_A); end
    idle_inputs();
    wait_drain();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL kill_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_same_cycle_kill();
    drive_alu(5'd9, 32'h1);
    drive_ld(5'd9, 32'h2);
    exp_q.push_back({5'd9, 32'h1});
    cycle();
    idle_inputs();
    checks++; if (bus.WE !== 1'b1 || bus.W_Data !== 32'h1) begin
      failures++; $display("FAIL same_alu: got we=%b data=%h required we=1 data=1", bus.WE, bus.W_Data);
    end
    checks++; if (bus.COUNT !== 3'd1) begin failures++; $display("FAIL same_count: got %0d required 1", bus.COUNT); end
    cycle();
    checks++; if (bus.WE !== 1'b0) begin failures++; $display("FAIL same_dead_pop: got we=%b required 0", bus.WE); end
    wait_drain();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL same_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_hazard();
    drive_alu(5'd0, 32'h0);
    drive_ld(5'd3, 32'hABC);
    bus.R_Addr_A = 5'd3;
    bus.R_Addr_B = 5'd0;
    cycle();
    bus.LD_VALID = 1'b0;
    #1;
    checks++; if (bus.HAZ_A !== 1'b1) begin failures++; $display("FAIL haz_a_queued: got %b required 1", bus.HAZ_A); end
    checks++; if (bus.HAZ_B !== 1'b0) begin failures++; $display("FAIL haz_b_r0: got %b required 0", bus.HAZ_B); end
    bus.R_Addr_B = 5'd4;
    #1;
    checks++; if (bus.HAZ_B !== 1'b0) begin failures++; $display("FAIL haz_b_other: got %b required 0", bus.HAZ_B); end
    bus.R_Addr_B = 5'd3;
    #1;
    checks++; if (bus.HAZ_B !== 1'b1) begin failures++; $display("FAIL haz_b_match: got %b required 1", bus.HAZ_B); end
    bus.R_Addr_B = 5'd0;
    cycle();
    bus.ALU_VALID = 1'b0;
    exp_q.push_back({5'd3, 32'hABC});
    cycle();
    checks++; if (bus.WE !== 1'b1 || bus.HAZ_A !== 1'b1) begin
      failures++; $display("FAIL haz_a_writing: got we=%b haz=%b required we=1 haz=1", bus.WE, bus.HAZ_A);
    end
    cycle();
    checks++; if (bus.HAZ_A !== 1'b0) begin failures++; $display("FAIL haz_a_retired: got %b required 0", bus.HAZ_A); end
    idle_inputs();
    wait_drain();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL haz_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_priority();
    test_kill();
    test_same_cycle_kill();
    test_hazard();
    repeat (3) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
